// File: rtl/flash_reader_pkg.sv
// Shared types and constants for the boot-flash SPI reader.
//   state_e         : top-level transfer state
//   ReadCommand     : flash READ opcode
//   AddressBitWidth : flash byte-address width
//   pack_le()       : reorders a wire-order word into little-endian byte order
package flash_reader_pkg;

  typedef enum logic [2:0] {
    Idle,
    SendCommand,
    SendAddress,
    ReceiveData,
    Deselect
  } state_e;

  localparam logic [7:0]  ReadCommand     = 8'h03;
  localparam int unsigned AddressBitWidth = 24;
  localparam int unsigned WordBitWidth    = 32;
  localparam int unsigned BitCntBitWidth  = 5;

  // The shift register receives the first byte in [31:24]; the port wants it in [7:0].
  function automatic logic [WordBitWidth-1:0] pack_le(input logic [WordBitWidth-1:0] wire_word);
    return {wire_word[7:0], wire_word[15:8], wire_word[23:16], wire_word[31:24]};
  endfunction

endpackage

// File: rtl/flash_reader_spi_bit_engine.sv
// SPI mode-0 bit engine: half-period phase counter, flash_clk generation,
// MOSI shift-out and MISO shift-in through one 32-bit shift register.
//   run          : engine active; when low the clock is parked low
//   stall        : hold the current low phase (backpressure)
//   load         : load load_data into the shift register, restart bit count
//   tx_en        : next MOSI bit is driven from the shift register, else 0
//   flash_clk    : SPI clock (registered)
//   flash_mosi   : SPI data out (registered)
//   fall_c       : this clk edge ends a high phase; MISO is sampled here
//   bit_cnt      : bits completed in the current 32-bit group (before fall_c)
//   shift_word   : shift register contents
//   shift_next_c : shift register value after this edge
module flash_reader_spi_bit_engine
  import flash_reader_pkg::*;
#(
  parameter int unsigned ClkHalfPeriod = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      run,
  input  logic                      stall,
  input  logic                      load,
  input  logic [WordBitWidth-1:0]   load_data,
  input  logic                      tx_en,
  input  logic                      flash_miso,
  output logic                      flash_clk,
  output logic                      flash_mosi,
  output logic                      fall_c,
  output logic [BitCntBitWidth-1:0] bit_cnt,
  output logic [WordBitWidth-1:0]   shift_word,
  output logic [WordBitWidth-1:0]   shift_next_c
);

  localparam int unsigned         PhaseBitWidth = 8;
  localparam logic [PhaseBitWidth-1:0] HalfLast = PhaseBitWidth'(ClkHalfPeriod - 1);

  logic [PhaseBitWidth-1:0]  phase_q, phase_d;
  logic                      sclk_q, sclk_d;
  logic                      mosi_q, mosi_d;
  logic [WordBitWidth-1:0]   sreg_q, sreg_d;
  logic [BitCntBitWidth-1:0] bit_cnt_q, bit_cnt_d;
  logic                      rise_c;

  // Phase counting, clock toggling and shifting.
  always_comb begin
    phase_d   = phase_q;
    sclk_d    = sclk_q;
    sreg_d    = sreg_q;
    bit_cnt_d = bit_cnt_q;
    rise_c    = run && !stall && !sclk_q && (phase_q == HalfLast);
    fall_c    = run && sclk_q && (phase_q == HalfLast);
    if (load) begin
      sreg_d    = load_data;
      bit_cnt_d = '0;
      phase_d   = '0;
      sclk_d    = 1'b0;
    end else if (!run) begin
      phase_d = '0;
      sclk_d  = 1'b0;
    end else if (rise_c || fall_c) begin
      phase_d = '0;
      sclk_d  = !sclk_q;
      if (fall_c) begin
        sreg_d    = {sreg_q[WordBitWidth-2:0], flash_miso};
        bit_cnt_d = bit_cnt_q + BitCntBitWidth'(1);
      end
    end else if (!stall) begin
      phase_d = phase_q + PhaseBitWidth'(1);
    end
    // MOSI only moves on load or fall, i.e. at the start of a low phase.
    mosi_d = tx_en && sreg_d[WordBitWidth-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q   <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      sreg_q    <= '0;
      bit_cnt_q <= '0;
    end else begin
      phase_q   <= phase_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      sreg_q    <= sreg_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign flash_clk    = sclk_q;
  assign flash_mosi   = mosi_q;
  assign bit_cnt      = bit_cnt_q;
  assign shift_word   = sreg_q;
  assign shift_next_c = sreg_d;

endmodule

// File: rtl/flash_reader.sv
// Streams a region of the boot flash out as little-endian 32-bit words.
//   start/flash_address/word_count : transfer request, captured while idle
//   busy/done                      : transfer status, done is a 1-cycle pulse
//   data_out/data_out_valid/ready  : word output with valid/ready handshake
//   word_index                     : 0-based index of data_out in the transfer
//   flash_clk/cs_n/mosi/miso       : SPI mode-0 pins
module flash_reader
  import flash_reader_pkg::*;
#(
  parameter int unsigned ClkHalfPeriod     = 1,
  parameter int unsigned WordCountBitWidth = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [AddressBitWidth-1:0]   flash_address,
  input  logic [WordCountBitWidth-1:0] word_count,
  output logic                         busy,
  output logic                         done,
  output logic [WordBitWidth-1:0]      data_out,
  output logic                         data_out_valid,
  input  logic                         data_out_ready,
  output logic [WordCountBitWidth-1:0] word_index,
  output logic                         flash_clk,
  output logic                         flash_cs_n,
  output logic                         flash_mosi,
  input  logic                         flash_miso
);

  localparam int unsigned DeselBitWidth = 9;
  localparam logic [DeselBitWidth-1:0] DeselLast = DeselBitWidth'(2 * ClkHalfPeriod - 1);

  state_e                         state_q, state_d;
  logic                           busy_q, busy_d;
  logic                           done_q, done_d;
  logic                           cs_n_q, cs_n_d;
  logic                           out_valid_q, out_valid_d;
  logic [WordBitWidth-1:0]        out_data_q, out_data_d;
  logic [WordCountBitWidth-1:0]   out_index_q, out_index_d;
  logic [WordCountBitWidth-1:0]   rx_index_q, rx_index_d;
  logic [WordCountBitWidth-1:0]   words_left_q, words_left_d;
  logic                           pending_q, pending_d;
  logic [DeselBitWidth-1:0]       desel_cnt_q, desel_cnt_d;

  logic                           load_c, tx_en_c, run_c, fall_c, out_free_c, push_c;
  logic [WordBitWidth-1:0]        push_word_c;
  logic [BitCntBitWidth-1:0]      bit_cnt;
  logic [WordBitWidth-1:0]        shift_word, shift_next_c;

  assign run_c      = (state_q == SendCommand) || (state_q == SendAddress) ||
                      (state_q == ReceiveData);
  assign tx_en_c    = (state_d == SendCommand) || (state_d == SendAddress);
  assign out_free_c = !out_valid_q || data_out_ready;

  flash_reader_spi_bit_engine #(
    .ClkHalfPeriod(ClkHalfPeriod)
  ) u_engine (
    .clk          (clk),
    .rst          (rst),
    .run          (run_c),
    .stall        (pending_q),
    .load         (load_c),
    .load_data    ({ReadCommand, flash_address}),
    .tx_en        (tx_en_c),
    .flash_miso   (flash_miso),
    .flash_clk    (flash_clk),
    .flash_mosi   (flash_mosi),
    .fall_c       (fall_c),
    .bit_cnt      (bit_cnt),
    .shift_word   (shift_word),
    .shift_next_c (shift_next_c)
  );

  // Transfer sequencing, word hand-off and output register.
  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    cs_n_d       = cs_n_q;
    out_valid_d  = out_valid_q && !data_out_ready;
    out_data_d   = out_data_q;
    out_index_d  = out_index_q;
    rx_index_d   = rx_index_q;
    words_left_d = words_left_q;
    pending_d    = pending_q;
    desel_cnt_d  = '0;
    load_c       = 1'b0;
    push_c       = 1'b0;
    push_word_c  = shift_next_c;

    unique case (state_q)
      Idle: begin
        if (start) begin
          if (word_count == '0) begin
            done_d = 1'b1;
          end else begin
            state_d      = SendCommand;
            busy_d       = 1'b1;
            cs_n_d       = 1'b0;
            load_c       = 1'b1;
            words_left_d = word_count;
            rx_index_d   = '0;
          end
        end
      end
      SendCommand: begin
        if (fall_c && (bit_cnt == BitCntBitWidth'(7))) state_d = SendAddress;
      end
      SendAddress: begin
        if (fall_c && (bit_cnt == BitCntBitWidth'(31))) state_d = ReceiveData;
      end
      ReceiveData: begin
        if (fall_c && (bit_cnt == BitCntBitWidth'(31))) begin
          words_left_d = words_left_q - WordCountBitWidth'(1);
          if (out_free_c) begin
            push_c = 1'b1;
            if (words_left_q == WordCountBitWidth'(1)) begin
              state_d = Deselect;
              cs_n_d  = 1'b1;
            end
          end else begin
            // Output still occupied: park the word in the shift register, clock held low.
            pending_d = 1'b1;
          end
        end else if (pending_q && out_free_c) begin
          push_c      = 1'b1;
          push_word_c = shift_word;
          pending_d   = 1'b0;
          if (words_left_q == '0) begin
            state_d = Deselect;
            cs_n_d  = 1'b1;
          end
        end
      end
      Deselect: begin
        if (desel_cnt_q == DeselLast) begin
          state_d = Idle;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          desel_cnt_d = desel_cnt_q + DeselBitWidth'(1);
        end
      end
      default: state_d = Idle;
    endcase

    if (push_c) begin
      out_valid_d = 1'b1;
      out_data_d  = pack_le(push_word_c);
      out_index_d = rx_index_q;
      rx_index_d  = rx_index_q + WordCountBitWidth'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= Idle;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cs_n_q       <= 1'b1;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_index_q  <= '0;
      rx_index_q   <= '0;
      words_left_q <= '0;
      pending_q    <= 1'b0;
      desel_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      cs_n_q       <= cs_n_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_index_q  <= out_index_d;
      rx_index_q   <= rx_index_d;
      words_left_q <= words_left_d;
      pending_q    <= pending_d;
      desel_cnt_q  <= desel_cnt_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign flash_cs_n     = cs_n_q;
  assign data_out       = out_data_q;
  assign data_out_valid = out_valid_q;
  assign word_index     = out_index_q;

endmodule

// File: tb/tb_flash_reader.sv
// Bench for flash_reader: two instances (half period 1 and 3) share one
// behavioural SPI flash whose byte at address A is A[7:0].
module tb_flash_reader;

  typedef struct {
    logic        sel;        // 0: half period 1, 1: half period 3
    logic [23:0] addr;
    logic [15:0] count;
    int          hold;       // cycles with ready=0 after first valid
    logic        poke;       // issue a second start while busy
    logic [31:0] exp_first;
    logic [31:0] exp_last;
  } xfer_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start1 = 1'b0, start3 = 1'b0;
  logic [23:0] flash_address = '0;
  logic [15:0] word_count = '0;
  logic        ready = 1'b1;
  logic        miso = 1'b0;
  logic        sel = 1'b0;

  logic        busy1, done1, valid1, fclk1, cs1, mosi1;
  logic        busy3, done3, valid3, fclk3, cs3, mosi3;
  logic [31:0] data1, data3;
  logic [15:0] idx1, idx3;

  logic        m_busy, m_done, m_valid, m_fclk, m_cs_n, m_mosi;
  logic [31:0] m_data;
  logic [15:0] m_idx;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  flash_reader #(.ClkHalfPeriod(1), .WordCountBitWidth(16)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .flash_address(flash_address),
    .word_count(word_count), .busy(busy1), .done(done1), .data_out(data1),
    .data_out_valid(valid1), .data_out_ready(ready), .word_index(idx1),
    .flash_clk(fclk1), .flash_cs_n(cs1), .flash_mosi(mosi1), .flash_miso(miso));

  flash_reader #(.ClkHalfPeriod(3), .WordCountBitWidth(16)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .flash_address(flash_address),
    .word_count(word_count), .busy(busy3), .done(done3), .data_out(data3),
    .data_out_valid(valid3), .data_out_ready(ready), .word_index(idx3),
    .flash_clk(fclk3), .flash_cs_n(cs3), .flash_mosi(mosi3), .flash_miso(miso));

  assign m_busy  = sel ? busy3  : busy1;
  assign m_done  = sel ? done3  : done1;
  assign m_valid = sel ? valid3 : valid1;
  assign m_fclk  = sel ? fclk3  : fclk1;
  assign m_cs_n  = sel ? cs3    : cs1;
  assign m_mosi  = sel ? mosi3  : mosi1;
  assign m_data  = sel ? data3  : data1;
  assign m_idx   = sel ? idx3   : idx1;

  // Flash model: captures command+address on rising flash_clk, drives data on falling.
  int          mbits = 0;
  int          rises = 0;
  int          mosi_hi = 0;
  int          bi = 0;
  logic [31:0] cap_ca = '0;
  logic [7:0]  m_byte = '0;

  always @(posedge m_fclk or negedge m_fclk or posedge m_cs_n) begin
    if (m_cs_n) begin
      mbits = 0;
    end else if (m_fclk) begin
      if (mbits < 32) cap_ca = {cap_ca[30:0], m_mosi};
      else if (m_mosi) mosi_hi++;
      mbits++;
      rises++;
    end else if (mbits >= 32) begin
      bi     = mbits - 32;
      m_byte = 8'(int'(cap_ca[23:0]) + bi / 8);
      miso   = m_byte[3'(7 - bi % 8)];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] exp_word(input logic [23:0] a, input int i);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = 8'(int'(a) + 4 * i + k);
    return w;
  endfunction

  task automatic run_xfer(input xfer_t v);
    int h, budget, cyc, got, run, hi_bad, lo_bad, desel, r0, mh0;
    int hold_left, unstable, low_streak;
    logic prev, done_seen, held;
    logic [31:0] w_first, w_last, hold_data;
    logic [15:0] hold_idx;
    h = v.sel ? 3 : 1;
    sel = v.sel;
    flash_address = v.addr;
    word_count = v.count;
    ready = (v.hold == 0);
    @(posedge clk); #1;
    r0 = rises;
    mh0 = mosi_hi;
    if (v.sel) start3 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    start3 = 1'b0;
    check("busy_after_start", 32'(m_busy), 32'(1));
    check("cs_low_after_start", 32'(m_cs_n), 32'(0));
    budget = (32 + 32 * int'(v.count)) * 2 * h + v.hold + 100;
    cyc = 0; got = 0; done_seen = 1'b0; held = 1'b0; prev = m_fclk; run = 1;
    hi_bad = 0; lo_bad = 0; desel = 0; hold_left = 0; unstable = 0; low_streak = 0;
    w_first = '0; w_last = '0; hold_data = '0; hold_idx = '0;
    while (!done_seen && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
      if (v.poke && cyc == 10) begin
        flash_address = 24'hABCDEF;
        if (v.sel) start3 = 1'b1; else start1 = 1'b1;
      end else begin
        start1 = 1'b0;
        start3 = 1'b0;
      end
      if (m_fclk != prev) begin
        if (prev) begin
          if (run != h) hi_bad++;
        end else if (run != h) begin
          lo_bad++;
        end
        prev = m_fclk;
        run = 1;
      end else begin
        run++;
      end
      if (m_done) begin
        done_seen = 1'b1;
        check("done_busy_low", 32'(m_busy), 32'(0));
        check("done_cs_high", 32'(m_cs_n), 32'(1));
      end else if (m_busy && m_cs_n) begin
        desel++;
      end
      if (hold_left > 0) begin
        if (m_data !== hold_data || m_idx !== hold_idx) unstable++;
        if (m_fclk) low_streak = 0; else low_streak++;
        hold_left--;
        if (hold_left == 0) begin
          check("hold_data_stable", 32'(unstable), 32'(0));
          check("hold_clk_frozen", 32'(low_streak >= 20), 32'(1));
          check("hold_cs_low", 32'(m_cs_n), 32'(0));
          ready = 1'b1;
        end
      end else if (!held && v.hold > 0 && m_valid) begin
        held = 1'b1;
        hold_data = m_data;
        hold_idx = m_idx;
        hold_left = v.hold;
      end
      if (m_valid && ready) begin
        check("word_data", m_data, exp_word(v.addr, got));
        check("word_index", 32'(m_idx), 32'(got));
        if (got == 0) w_first = m_data;
        w_last = m_data;
        got++;
      end
    end
    check("done_seen", 32'(done_seen), 32'(1));
    check("word_total", 32'(got), 32'(v.count));
    check("first_word", w_first, v.exp_first);
    check("last_word", w_last, v.exp_last);
    check("cmd_addr_mosi", cap_ca, {8'h03, v.addr});
    check("mosi_zero_in_data", 32'(mosi_hi - mh0), 32'(0));
    check("bit_count", 32'(rises - r0), 32'(32 + 32 * int'(v.count)));
    check("deselect_cycles", 32'(desel), 32'(2 * h));
    check("clk_high_phase", 32'(hi_bad), 32'(0));
    if (v.hold == 0) check("clk_low_phase", 32'(lo_bad), 32'(0));
    @(posedge clk); #1;
    check("done_one_cycle", 32'(m_done), 32'(0));
    check("valid_drained", 32'(m_valid), 32'(0));
  endtask

  xfer_t vec[5];
  xfer_t post;
  int    cyc;

  initial begin
    vec[0] = '{1'b0, 24'h000000, 16'd4, 0,   1'b0, 32'h03020100, 32'h0F0E0D0C};
    vec[1] = '{1'b0, 24'h123456, 16'd1, 0,   1'b0, 32'h59585756, 32'h59585756};
    vec[2] = '{1'b0, 24'h0000F0, 16'd3, 100, 1'b0, 32'hF3F2F1F0, 32'hFBFAF9F8};
    vec[3] = '{1'b0, 24'h0001FE, 16'd2, 0,   1'b1, 32'h0100FFFE, 32'h05040302};
    vec[4] = '{1'b1, 24'h000000, 16'd4, 0,   1'b0, 32'h03020100, 32'h0F0E0D0C};
    post   = '{1'b0, 24'h000040, 16'd2, 0,   1'b0, 32'h43424140, 32'h47464544};

    // Reset values on both instances.
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs_n", 32'({cs1, cs3}), 32'(2'b11));
    check("rst_flash_clk", 32'({fclk1, fclk3}), 32'(0));
    check("rst_mosi", 32'({mosi1, mosi3}), 32'(0));
    check("rst_busy_done", 32'({busy1, busy3, done1, done3}), 32'(0));
    check("rst_valid", 32'({valid1, valid3}), 32'(0));
    check("rst_data_out", data1 | data3, 32'(0));
    check("rst_word_index", 32'(idx1 | idx3), 32'(0));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) run_xfer(vec[i]);

    // Zero-length request: immediate done, chip never selected.
    sel = 1'b0;
    word_count = 16'd0;
    flash_address = 24'h000010;
    @(posedge clk); #1;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    check("zero_done", 32'(m_done), 32'(1));
    check("zero_busy", 32'(m_busy), 32'(0));
    check("zero_cs", 32'(m_cs_n), 32'(1));
    @(posedge clk); #1;
    check("zero_done_pulse", 32'(m_done), 32'(0));
    check("zero_cs_after", 32'(m_cs_n), 32'(1));

    // Asynchronous reset during the address phase, while flash_clk is high.
    word_count = 16'd2;
    flash_address = 24'h000100;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    cyc = 0;
    while (!(cyc >= 20 && m_fclk) && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("abort_in_address_phase", 32'({m_busy, m_cs_n, m_fclk}), 32'(3'b101));
    #2;
    rst = 1'b1;
    #1;
    check("abort_cs_high", 32'(m_cs_n), 32'(1));
    check("abort_clk_low", 32'(m_fclk), 32'(0));
    check("abort_busy", 32'(m_busy), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    run_xfer(post);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
